// File: rtl/btn_pkg.sv
// Shared definitions for the push-button decoder: press FSM states and
// default cycle counts derived from the 12 MHz board clock.
package btn_pkg;

   localparam int unsigned CLK_HZ             = 12_000_000;
   localparam int unsigned DEBOUNCE_DEFAULT   = CLK_HZ / 100;
   localparam int unsigned LONG_PRESS_DEFAULT = CLK_HZ;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PRESSED   = 2'd1,
      LONG_HELD = 2'd2
   } press_state_t;

   // Counter width for a count range of n, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, polarity normalisation and debounce counter.
// A clean pin change reaches level DEBOUNCE_CYCLES+2 edges later.
module btn_debounce
   import btn_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
   parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic level
);

   localparam int unsigned   DW       = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic          IDLE_RAW = BTN_ACTIVE_LOW;

   logic          sync_1;
   logic          sync_2;
   logic          sync_level;
   logic          stable;
   logic [DW-1:0] deb_cnt;

   assign sync_level = sync_2 ^ BTN_ACTIVE_LOW;
   assign level      = stable;

   // Synchroniser resets to the raw "released" value so no false edge follows reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_1  <= IDLE_RAW;
         sync_2  <= IDLE_RAW;
         stable  <= 1'b0;
         deb_cnt <= '0;
      end else begin
         sync_1 <= btn;
         sync_2 <= sync_1;
         if (sync_level == stable) begin
            deb_cnt <= '0;
         end else if (deb_cnt == DEB_LAST) begin
            stable  <= sync_level;
            deb_cnt <= '0;
         end else begin
            deb_cnt <= deb_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/button_press_decoder.sv
// Debounced button with short/long press classification and a 2-bit MODE register.
// Pulses are registered, one cycle wide; LONG_PRESS fires LONG_PRESS_CYCLES+1 edges after BTN_LEVEL rises.
module button_press_decoder
   import btn_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES   = DEBOUNCE_DEFAULT,
   parameter int unsigned LONG_PRESS_CYCLES = LONG_PRESS_DEFAULT,
   parameter bit          BTN_ACTIVE_LOW    = 1'b1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       BTN,
   output logic       BTN_LEVEL,
   output logic       SHORT_PRESS,
   output logic       LONG_PRESS,
   output logic [1:0] MODE
);

   localparam int unsigned   HW        = cnt_width(LONG_PRESS_CYCLES);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);

   logic          level;
   press_state_t  state_q, state_d;
   logic [HW-1:0] hold_q, hold_d;
   logic          short_q, short_d;
   logic          long_q, long_d;
   logic [1:0]    mode_q, mode_d;

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
   ) u_debounce (
      .clk   (CLK),
      .rst   (RST),
      .btn   (BTN),
      .level (level)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         hold_q  <= '0;
         short_q <= 1'b0;
         long_q  <= 1'b0;
         mode_q  <= 2'd0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         short_q <= short_d;
         long_q  <= long_d;
         mode_q  <= mode_d;
      end
   end

   // Release is tested before the threshold so a coinciding release yields SHORT.
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      short_d = 1'b0;
      long_d  = 1'b0;
      mode_d  = mode_q;
      case (state_q)
         IDLE: begin
            if (level) begin
               state_d = PRESSED;
               hold_d  = '0;
            end
         end
         PRESSED: begin
            if (!level) begin
               state_d = IDLE;
               short_d = 1'b1;
               mode_d  = mode_q + 2'd1;
            end else if (hold_q == HOLD_LAST) begin
               state_d = LONG_HELD;
               long_d  = 1'b1;
               mode_d  = 2'd0;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         LONG_HELD: begin
            if (!level) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign BTN_LEVEL   = level;
   assign SHORT_PRESS = short_q;
   assign LONG_PRESS  = long_q;
   assign MODE        = mode_q;

endmodule

// File: tb/tb_button_press_decoder.sv
// Randomised and directed bench for button_press_decoder against a timestamp-based press model.
module tb_button_press_decoder;

   localparam int D = 4;
   localparam int L = 20;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       BTN = 1'b1;
   logic       BTN_LEVEL;
   logic       SHORT_PRESS;
   logic       LONG_PRESS;
   logic [1:0] MODE;

   int n_checks = 0;
   int n_fail   = 0;
   int sp_cnt   = 0;
   int lp_cnt   = 0;

   button_press_decoder #(
      .DEBOUNCE_CYCLES   (D),
      .LONG_PRESS_CYCLES (L),
      .BTN_ACTIVE_LOW    (1'b1)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .BTN         (BTN),
      .BTN_LEVEL   (BTN_LEVEL),
      .SHORT_PRESS (SHORT_PRESS),
      .LONG_PRESS  (LONG_PRESS),
      .MODE        (MODE)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: raw pin history, run-length debounce, and press age by edge timestamp.
   bit r1 = 1'b1, r2 = 1'b1;
   bit m_level = 1'b0, m_short = 1'b0, m_long = 1'b0, m_valid = 1'b0;
   bit active = 1'b0, long_done = 1'b0;
   bit lvl_before, pressed_sync;
   int m_mode = 0, run = 0, edge_n = 0, press_start = 0;

   always @(posedge CLK) begin
      edge_n++;
      if (RST) begin
         r1 = 1'b1; r2 = 1'b1;
         m_level = 1'b0; run = 0;
         active = 1'b0; long_done = 1'b0;
         m_short = 1'b0; m_long = 1'b0; m_mode = 0;
         m_valid = 1'b1;
      end else begin
         lvl_before   = m_level;
         pressed_sync = ~r2;
         m_short = 1'b0;
         m_long  = 1'b0;
         if (!active) begin
            if (lvl_before) begin
               active = 1'b1; long_done = 1'b0; press_start = edge_n;
            end
         end else if (!lvl_before) begin
            if (!long_done) begin
               m_short = 1'b1;
               m_mode  = (m_mode + 1) % 4;
            end
            active = 1'b0;
         end else if (!long_done && (edge_n - press_start) == L) begin
            m_long = 1'b1; m_mode = 0; long_done = 1'b1;
         end
         if (pressed_sync != m_level) begin
            run++;
            if (run == D) begin
               m_level = pressed_sync;
               run = 0;
            end
         end else begin
            run = 0;
         end
         r2 = r1;
         r1 = BTN;
      end
   end

   always @(negedge CLK) begin
      if (m_valid) begin
         check("btn_level", BTN_LEVEL, m_level);
         check("short_press", SHORT_PRESS, m_short);
         check("long_press", LONG_PRESS, m_long);
         check("mode", MODE, m_mode);
      end
      if (SHORT_PRESS === 1'b1) sp_cnt++;
      if (LONG_PRESS === 1'b1) lp_cnt++;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic wait_level(input logic val, output int edges);
      edges = -1;
      for (int i = 1; i <= 200; i++) begin
         @(posedge CLK);
         #1;
         if (BTN_LEVEL === val) begin
            edges = i;
            break;
         end
      end
   endtask

   task automatic wait_long(output int edges);
      edges = -1;
      for (int i = 1; i <= 200; i++) begin
         @(posedge CLK);
         #1;
         if (LONG_PRESS === 1'b1) begin
            edges = i;
            break;
         end
      end
   endtask

   task automatic do_reset(input logic b);
      RST = 1'b1;
      BTN = b;
      step(3);
      RST = 1'b0;
   endtask

   task automatic short_press(input int hold);
      BTN = 1'b0;
      step(hold);
      BTN = 1'b1;
      step(15);
   endtask

   int e, e2, sp0, lp0, kind, len;
   int exp_modes [4];

   initial begin
      exp_modes[0] = 2; exp_modes[1] = 3; exp_modes[2] = 0; exp_modes[3] = 1;

      // 1: reset with button held, then first debounced rise
      do_reset(1'b0);
      check("t1_rst_level", BTN_LEVEL, 0);
      check("t1_rst_mode", MODE, 0);
      check("t1_rst_pulses", {SHORT_PRESS, LONG_PRESS}, 0);
      wait_level(1'b1, e);
      check("t1_rise_latency", e, 6);
      BTN = 1'b1;
      step(15);

      // 2: bounce then settle pressed
      do_reset(1'b1);
      step(12);
      BTN = 1'b1; step(1);
      BTN = 1'b0; step(1);
      BTN = 1'b1; step(1);
      BTN = 1'b0;
      wait_level(1'b1, e);
      check("t2_bounce_latency", e, 6);

      // 3: single short press
      do_reset(1'b1);
      step(12);
      sp0 = sp_cnt; lp0 = lp_cnt;
      short_press(10);
      check("t3_short_count", sp_cnt - sp0, 1);
      check("t3_long_count", lp_cnt - lp0, 0);
      check("t3_mode", MODE, 1);

      // 4: four short presses wrap MODE
      sp0 = sp_cnt;
      for (int k = 0; k < 4; k++) begin
         short_press(12);
         check("t4_mode", MODE, exp_modes[k]);
      end
      check("t4_short_count", sp_cnt - sp0, 4);
      short_press(12);
      check("t4_mode_to_2", MODE, 2);

      // 5: long press from MODE=2
      sp0 = sp_cnt; lp0 = lp_cnt;
      BTN = 1'b0;
      wait_level(1'b1, e);
      check("t5_rise_latency", e, 6);
      wait_long(e2);
      check("t5_long_latency", e2, 21);
      check("t5_mode_cleared", MODE, 0);
      step(23);
      BTN = 1'b1;
      step(15);
      check("t5_short_count", sp_cnt - sp0, 0);
      check("t5_long_count", lp_cnt - lp0, 1);

      // 6: reset mid-press with button still held
      short_press(12);
      check("t6_mode_before", MODE, 1);
      BTN = 1'b0;
      wait_level(1'b1, e);
      step(11);
      sp0 = sp_cnt; lp0 = lp_cnt;
      RST = 1'b1;
      step(2);
      RST = 1'b0;
      wait_level(1'b1, e);
      check("t6_rerise_latency", e, 6);
      check("t6_mode", MODE, 0);
      check("t6_pulses", (sp_cnt - sp0) + (lp_cnt - lp0), 0);
      BTN = 1'b1;
      step(20);

      // Random segments of held levels, bounces and occasional resets
      for (int s = 0; s < 250; s++) begin
         if ($urandom_range(0, 39) == 0) begin
            RST = 1'b1;
            step($urandom_range(1, 3));
            RST = 1'b0;
         end
         BTN  = 1'($urandom_range(0, 1));
         kind = $urandom_range(0, 3);
         if (kind == 0)      len = $urandom_range(1, 3);
         else if (kind == 3) len = $urandom_range(20, 45);
         else                len = $urandom_range(4, 30);
         step(len);
      end
      BTN = 1'b1;
      step(20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
